multiword_add_sequencer: RTL and testbench
==========================================

Name: multiword_add_sequencer

Overview:
- Adds two WIDTH*CHUNKS-bit operands by time-multiplexing one internal WIDTH+1-bit ripple_carry_adder instance, one WIDTH-bit chunk per cycle, least-significant chunk first.
- Sits between a valid/ready operand source and a valid/ready result sink.
- Gives wide-operand addition for the area of a single narrow ripple adder, at the cost of CHUNKS cycles per operation.

Parameters:
- WIDTH, 8, chunk width in bits (per-cycle adder slice); must be >= 1.
- CHUNKS, 4, number of chunks per operand; must be >= 2.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_valid  input  1  operand source has a valid operand pair.
- o_ready  output  1  block can accept an operand pair.
- i_add_term1  input  WIDTH*CHUNKS  operand A.
- i_add_term2  input  WIDTH*CHUNKS  operand B.
- o_valid  output  1  o_result holds a completed sum.
- i_ready  input  1  result sink accepts o_result.
- o_result  output  WIDTH*CHUNKS+1  sum; MSB is the final carry-out.
- o_busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; operand registers, result register, chunk index and carry register cleared to 0.
  - o_ready=1 and o_valid=0 once reset deasserts; o_result=0 and o_busy=0.
  - While i_rst is high, o_ready=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid&&o_ready: capture both operands, set idx=0 and carry=0, go to RUN.
- RUN (o_ready=0):
  - Each cycle the adder is fed {A[idx],1'b1} and {B[idx],carry}, both WIDTH+1 bits.
  - Adder output bits [WIDTH:1] give the chunk sum; bit [WIDTH+1] is the chunk carry-out.
  - The LSB-extension trick is mandatory: it gives A+B+carry with no carry-in port on the adder.
  - Chunk sum is written to result slice idx; carry register takes the chunk carry-out.
  - idx increments each cycle. In the cycle where idx==CHUNKS-1, the final carry is written to result MSB and state goes to DONE.
- DONE:
  - o_valid=1; o_result stable; o_ready=0.
  - On i_ready: o_valid drops next cycle and state goes to IDLE.
  - Back-to-back acceptance in the same cycle as result handoff is not supported; one bubble cycle is required.
- Latency: pair accepted at edge k -> o_valid high after edge k+CHUNKS. Throughput is one operation per CHUNKS+2 cycles minimum.
- Width and wrap rules:
  - Sum is exact, with no overflow: the MSB holds the carry.
  - idx width is clog2(CHUNKS); idx never wraps past CHUNKS-1.
- Input changes:
  - i_add_term1/2 changing after capture has no effect.
  - i_valid while not in IDLE is ignored. The source holds the pair; it is never dropped because o_ready=0.
- i_ready asserted outside DONE: ignored.
- Reset asserted mid-RUN or mid-DONE: operation aborted, no o_valid pulse, all state returns to reset values.
- o_result holds its last value in IDLE until the next operation overwrites chunks, except after reset (0).

Optional Feature:
- Macro: MULTIWORD_ADD_SEQUENCER_SUB_EN.
- Defined:
  - Adds port i_sub (input, 1), captured with the operands.
  - When the captured i_sub=1: B chunks are bit-inverted before the adder and initial carry=1, so the result is A-B in two's complement.
  - o_result MSB is the final carry: 1 = no borrow (A>=B unsigned), 0 = borrow.
  - When the captured i_sub=0: behaviour is identical to addition.
- Undefined: no i_sub port; add only; no inverter or mux logic synthesized.

Test Plan (WIDTH=8, CHUNKS=4):
- A=0x0000_0001, B=0x0000_0002 accepted at edge k -> o_valid after edge k+4, o_result=0x0_0000_0003, o_ready low from k to handoff.
- A=0x00FF_FFFF, B=0x0000_0001 -> o_result=0x0_0100_0000 (carry ripples across three chunk boundaries).
- A=0xFFFF_FFFF, B=0xFFFF_FFFF -> o_result=0x1_FFFF_FFFE; hold i_ready=0 for 5 cycles -> o_valid and o_result stable, i_valid held high meanwhile is not accepted.
- Accept A=0x1234_5678, B=0x1111_1111, assert i_rst after edge k+2 for one cycle -> no o_valid pulse, o_result=0, o_ready=1 after release; a following pair 5+7 completes with result 0x0_0000_000C.
- Two pairs presented continuously with i_ready=1 -> second accepted exactly CHUNKS+2 cycles after the first; results 0x0_0000_0003 then 0x0_0000_000C (pairs 1+2, 5+7).
- SUB_EN defined: A=0x0000_0005, B=0x0000_0007, i_sub=1 -> o_result=0x0_FFFF_FFFE (MSB 0 = borrow); A=7, B=5 -> 0x1_0000_0002.

Source files
------------

// File: rtl/multiword_add_sequencer_if.sv
// Operand/result handshake bundle for multiword_add_sequencer.
// Optional subtract port present when MULTIWORD_ADD_SEQUENCER_SUB_EN is defined.
interface multiword_add_sequencer_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned CHUNKS = 4
);
  logic                      i_valid;
  logic                      o_ready;
  logic [WIDTH*CHUNKS-1:0]   i_add_term1;
  logic [WIDTH*CHUNKS-1:0]   i_add_term2;
  logic                      o_valid;
  logic                      i_ready;
  logic [WIDTH*CHUNKS:0]     o_result;
  logic                      o_busy;
`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
  logic                      i_sub;
`endif

  modport slave (
`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
    input  i_sub,
`endif
    input  i_valid, i_add_term1, i_add_term2, i_ready,
    output o_ready, o_valid, o_result, o_busy
  );

  modport master (
`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
    output i_sub,
`endif
    output i_valid, i_add_term1, i_add_term2, i_ready,
    input  o_ready, o_valid, o_result, o_busy
  );
endinterface

// File: rtl/multiword_add_sequencer.sv
// Wide adder built from one narrow ripple-carry slice, one chunk per cycle,
// least-significant chunk first.
// Optional feature macro: MULTIWORD_ADD_SEQUENCER_SUB_EN (adds i_sub, A-B).

module ripple_carry_adder #(
  parameter int unsigned N = 9
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N:0]   o_sum
);
  // Bit-serial carry chain; o_sum[N] is the carry-out.
  always_comb begin
    logic c;
    c     = 1'b0;
    o_sum = '0;
    for (int unsigned i = 0; i < N; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ c;
      c        = (i_a[i] & i_b[i]) | (c & (i_a[i] ^ i_b[i]));
    end
    o_sum[N] = c;
  end
endmodule

module multiword_add_sequencer #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned CHUNKS = 4
) (
  input logic                     i_clk,
  input logic                     i_rst,
  multiword_add_sequencer_if.slave bus
);
  localparam int unsigned TW   = WIDTH * CHUNKS;
  localparam int unsigned IDXW = $clog2(CHUNKS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state;
  logic [TW-1:0]     r_a;
  logic [TW-1:0]     r_b;
  logic [TW:0]       r_result;
  logic [IDXW-1:0]   r_idx;
  logic              r_carry;
  logic              r_ready;
  logic              r_valid;
  logic              r_busy;
`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
  logic              r_sub;
`endif

  logic [WIDTH-1:0]  w_a_chunk;
  logic [WIDTH-1:0]  w_b_chunk;
  logic [WIDTH:0]    w_op_a;
  logic [WIDTH:0]    w_op_b;
  logic [WIDTH+1:0]  w_sum;
  logic              w_init_carry;
  logic              w_last;

  // Current chunk selection and optional B inversion for subtraction.
  always_comb begin
    w_a_chunk = r_a[r_idx*WIDTH +: WIDTH];
`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
    w_b_chunk    = r_b[r_idx*WIDTH +: WIDTH] ^ {WIDTH{r_sub}};
    w_init_carry = bus.i_sub;
`else
    w_b_chunk    = r_b[r_idx*WIDTH +: WIDTH];
    w_init_carry = 1'b0;
`endif
    // LSB extension: 1 + carry in bit 0 propagates the carry into bit 1,
    // giving A+B+carry without a carry-in port on the adder.
    w_op_a = {w_a_chunk, 1'b1};
    w_op_b = {w_b_chunk, r_carry};
    w_last = (r_idx == IDXW'(CHUNKS - 1));
  end

  ripple_carry_adder #(.N(WIDTH + 1)) u_adder (
    .i_a   (w_op_a),
    .i_b   (w_op_b),
    .o_sum (w_sum)
  );

  // o_ready is forced low while reset is held.
  assign bus.o_ready  = r_ready & ~i_rst;
  assign bus.o_valid  = r_valid;
  assign bus.o_result = r_result;
  assign bus.o_busy   = r_busy;

  // Control FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
      r_sub    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_valid && r_ready) begin
            r_a     <= bus.i_add_term1;
            r_b     <= bus.i_add_term2;
            r_idx   <= '0;
            r_carry <= w_init_carry;
`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
            r_sub   <= bus.i_sub;
`endif
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_result[r_idx*WIDTH +: WIDTH] <= w_sum[WIDTH:1];
          r_carry <= w_sum[WIDTH+1];
          if (w_last) begin
            r_result[TW] <= w_sum[WIDTH+1];
            r_valid      <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.i_ready) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Self-checking bench for multiword_add_sequencer (WIDTH=8, CHUNKS=4).
module tb_multiword_add_sequencer;
  localparam int unsigned WIDTH  = 8;
  localparam int unsigned CHUNKS = 4;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  multiword_add_sequencer_if #(.WIDTH(WIDTH), .CHUNKS(CHUNKS)) bus ();

  multiword_add_sequencer #(.WIDTH(WIDTH), .CHUNKS(CHUNKS)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Reference: exact wide sum, or A + ~B + 1 for subtraction.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sub);
    if (sub) return {1'b0, a} + {1'b0, ~b} + 33'd1;
    return {1'b0, a} + {1'b0, b};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_sub(input logic sub);
`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
    bus.i_sub = sub;
`else
    if (sub) $display("note: subtract requested without feature, ignored");
`endif
  endtask

  // One full operation: accept, run with junk on the inputs, hold in DONE, hand off.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input int hold, input string tag);
    logic [32:0] exp;
    exp = model(a, b, sub);
    bus.i_add_term1 = a;
    bus.i_add_term2 = b;
    set_sub(sub);
    bus.i_valid = 1'b1;
    bus.i_ready = 1'b0;
    chk({tag, "_ready_idle"}, 64'(bus.o_ready), 64'd1);
    @(posedge clk); #1;
    chk({tag, "_busy_run"},  64'(bus.o_busy),  64'd1);
    chk({tag, "_ready_run"}, 64'(bus.o_ready), 64'd0);
    bus.i_add_term1 = $urandom;
    bus.i_add_term2 = $urandom;
    set_sub(1'($urandom_range(0, 1)));
    bus.i_ready = (hold == 0);
    repeat (CHUNKS - 1) begin
      @(posedge clk); #1;
      chk({tag, "_valid_run"}, 64'(bus.o_valid), 64'd0);
      chk({tag, "_ready_run"}, 64'(bus.o_ready), 64'd0);
    end
    @(posedge clk); #1;
    chk({tag, "_valid_done"}, 64'(bus.o_valid),  64'd1);
    chk({tag, "_result"},     64'(bus.o_result), 64'(exp));
    repeat (hold) begin
      @(posedge clk); #1;
      chk({tag, "_valid_hold"},  64'(bus.o_valid),  64'd1);
      chk({tag, "_result_hold"}, 64'(bus.o_result), 64'(exp));
      chk({tag, "_ready_hold"},  64'(bus.o_ready),  64'd0);
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_valid_after"},  64'(bus.o_valid),  64'd0);
    chk({tag, "_ready_after"},  64'(bus.o_ready),  64'd1);
    chk({tag, "_busy_after"},   64'(bus.o_busy),   64'd0);
    chk({tag, "_result_held"},  64'(bus.o_result), 64'(exp));
    bus.i_ready = 1'b0;
  endtask

  initial begin
    int acc1, acc2, nres, cyc;
    logic [32:0] res [0:3];
    logic will_accept;

    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_add_term1 = '0;
    bus.i_add_term2 = '0;
    set_sub(1'b0);
    rst = 1'b1;
    #1;
    chk("rst_ready",  64'(bus.o_ready),  64'd0);
    chk("rst_valid",  64'(bus.o_valid),  64'd0);
    chk("rst_result", 64'(bus.o_result), 64'd0);
    chk("rst_busy",   64'(bus.o_busy),   64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(bus.o_ready), 64'd1);
    @(posedge clk); #1;

    // Directed cases.
    do_op(32'h0000_0001, 32'h0000_0002, 1'b0, 0, "one_plus_two");
    do_op(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1, "ripple3");
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5, "max_hold5");

    // Reset in the middle of a run: no result, everything back to reset values.
    bus.i_add_term1 = 32'h1234_5678;
    bus.i_add_term2 = 32'h1111_1111;
    set_sub(1'b0);
    bus.i_valid = 1'b1;
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_ready_low", 64'(bus.o_ready),  64'd0);
    chk("midrst_result",    64'(bus.o_result), 64'd0);
    chk("midrst_busy",      64'(bus.o_busy),   64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_ready_rel", 64'(bus.o_ready),  64'd1);
    chk("midrst_valid_rel", 64'(bus.o_valid),  64'd0);
    repeat (6) begin
      @(posedge clk); #1;
      chk("midrst_no_valid", 64'(bus.o_valid), 64'd0);
    end
    bus.i_ready = 1'b0;
    do_op(32'd5, 32'd7, 1'b0, 0, "after_rst");

    // Continuous source and sink: acceptance spacing and result order.
    acc1 = -1; acc2 = -1; nres = 0; cyc = 0;
    bus.i_add_term1 = 32'd1;
    bus.i_add_term2 = 32'd2;
    bus.i_valid = 1'b1;
    bus.i_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      will_accept = bus.o_ready && bus.i_valid;
      if (bus.o_valid && nres < 4) begin
        res[nres] = bus.o_result;
        nres++;
      end
      @(posedge clk); #1;
      cyc++;
      if (will_accept) begin
        if (acc1 < 0) begin
          acc1 = cyc;
          bus.i_add_term1 = 32'd5;
          bus.i_add_term2 = 32'd7;
        end else if (acc2 < 0) begin
          acc2 = cyc;
          bus.i_valid = 1'b0;
        end
      end
    end
    bus.i_ready = 1'b0;
    chk("b2b_first_accept", 64'(acc1 >= 0), 64'd1);
    chk("b2b_spacing",      64'(acc2 - acc1), 64'(CHUNKS + 2));
    chk("b2b_nres",         64'(nres), 64'd2);
    chk("b2b_res0",         64'(res[0]), 64'h0_0000_0003);
    chk("b2b_res1",         64'(res[1]), 64'h0_0000_000C);

`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
    do_op(32'd5, 32'd7, 1'b1, 0, "sub_borrow");
    do_op(32'd7, 32'd5, 1'b1, 1, "sub_noborrow");
    chk("sub_const_a", 64'(model(32'd5, 32'd7, 1'b1)), 64'h0_FFFF_FFFE);
`endif

    // Randomized operations against the reference model.
    for (int n = 0; n < 20; n++) begin
      logic s;
`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      do_op($urandom, $urandom, s, int'($urandom_range(0, 2)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
